// File: rtl/max7219_frame_sequencer_if.sv
// Command channel between the frame sequencer and the MAX7219 serial driver.
// The sequencer (master) presents {IRreg, data} with a one-cycle str pulse;
// the driver (slave) answers with busy while the frame is shifting out.
interface max7219_frame_sequencer_if;
    logic       str;
    logic [7:0] IRreg;
    logic [7:0] data;
    logic       busy;

    modport master (
        output str,
        output IRreg,
        output data,
        input  busy
    );

    modport slave (
        input  str,
        input  IRreg,
        input  data,
        output busy
    );
endinterface

// File: rtl/max7219_frame_sequencer.sv
// MAX7219 frame sequencer: holds an 8x8 framebuffer, runs the controller init
// sequence after reset, then forwards only changed rows / control levels to the
// serial driver as {address, data} commands. An optional periodic refresh marks
// everything dirty so the panel recovers from corrupted controller state.
module max7219_frame_sequencer #(
    parameter logic [3:0]  INTENSITY   = 4'h8,
    parameter logic [2:0]  SCAN_LIMIT  = 3'd7,
    parameter logic [7:0]  DECODE      = 8'h00,
    parameter int unsigned REFRESH_DIV = 5000000,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                             sys_clk,
    input  logic                             rst,
    input  logic                             row_we_i,
    input  logic [2:0]                       row_addr_i,
    input  logic [7:0]                       row_data_i,
    input  logic                             disp_on_i,
    input  logic                             test_mode_i,
    max7219_frame_sequencer_if.master        drv,
    output logic                             ready_o,
    output logic                             ack_err_o
);

    localparam logic [7:0]  REG_DECODE    = 8'h09;
    localparam logic [7:0]  REG_INTENSITY = 8'h0A;
    localparam logic [7:0]  REG_SCANLIM   = 8'h0B;
    localparam logic [7:0]  REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0]  REG_TEST      = 8'h0F;
    localparam logic [2:0]  INIT_LAST     = 3'd4;
    localparam logic [15:0] ACK_LAST      = 16'(ACK_TIMEOUT - 1);
    localparam logic [31:0] REFRESH_LAST  = (REFRESH_DIV == 0) ? 32'd0 : 32'(REFRESH_DIV - 1);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_SELECT  = 3'd4,
        ST_IDLE    = 3'd5
    } state_t;

    // Init table: test mode first so a panel left in test mode goes dark early,
    // shutdown register last so the display only turns on once fully configured.
    function automatic logic [15:0] init_cmd(input logic [2:0] idx,
                                             input logic       tm,
                                             input logic       dn);
        logic [15:0] cmd;
        case (idx)
            3'd0:    cmd = {REG_TEST,      7'b0000000, tm};
            3'd1:    cmd = {REG_DECODE,    DECODE};
            3'd2:    cmd = {REG_INTENSITY, 4'b0000, INTENSITY};
            3'd3:    cmd = {REG_SCANLIM,   5'b00000, SCAN_LIMIT};
            3'd4:    cmd = {REG_SHUTDOWN,  7'b0000000, dn};
            default: cmd = 16'h0000;
        endcase
        return cmd;
    endfunction

    state_t      state_q;
    logic [7:0]  fb_q [8];
    logic [7:0]  row_dirty_q;
    logic [7:0]  row_dirty_d;
    logic [1:0]  ctrl_dirty_q;      // [1] shutdown reg, [0] test reg
    logic [1:0]  ctrl_dirty_d;
    logic        sent_disp_q;
    logic        sent_test_q;
    logic [31:0] refresh_cnt_q;
    logic [2:0]  init_idx_q;
    logic        init_done_q;
    logic [15:0] wait_cnt_q;
    logic        str_q;
    logic [7:0]  ir_q;
    logic [7:0]  data_q;
    logic        ack_err_q;

    logic        refresh_wrap_s;
    logic        disp_pend_s;
    logic        test_pend_s;
    logic        row_any_s;
    logic [2:0]  row_sel_s;
    logic        any_pending_s;
    logic        launch_s;
    logic        send_disp_s;
    logic        send_test_s;
    logic [7:0]  clr_row_s;
    logic [1:0]  clr_ctrl_s;
    logic [7:0]  cmd_addr_d;
    logic [7:0]  cmd_data_d;

    assign refresh_wrap_s = (REFRESH_DIV != 0) && (refresh_cnt_q == REFRESH_LAST);

    // Pending work: a control is pending when its level differs from what the
    // controller last received, or a refresh forced it; rows use the dirty mask.
    always_comb begin
        disp_pend_s   = (disp_on_i != sent_disp_q) | ctrl_dirty_q[1];
        test_pend_s   = (test_mode_i != sent_test_q) | ctrl_dirty_q[0];
        row_any_s     = |row_dirty_q;
        row_sel_s     = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            row_sel_s = row_dirty_q[i] ? 3'(i) : row_sel_s;
        end
        any_pending_s = disp_pend_s | test_pend_s | row_any_s;
    end

    // Command selection: init table while in INIT, otherwise shutdown reg >
    // test reg > lowest dirty row. A launch only happens while the driver is idle.
    always_comb begin
        cmd_addr_d  = 8'h00;
        cmd_data_d  = 8'h00;
        launch_s    = 1'b0;
        send_disp_s = 1'b0;
        send_test_s = 1'b0;
        clr_row_s   = 8'h00;
        clr_ctrl_s  = 2'b00;
        case (state_q)
            ST_INIT: begin
                launch_s                 = !drv.busy;
                {cmd_addr_d, cmd_data_d} = init_cmd(init_idx_q, test_mode_i, disp_on_i);
                send_test_s              = launch_s && (init_idx_q == 3'd0);
                send_disp_s              = launch_s && (init_idx_q == INIT_LAST);
            end
            ST_SELECT: begin
                if (disp_pend_s) begin
                    cmd_addr_d    = REG_SHUTDOWN;
                    cmd_data_d    = {7'b0000000, disp_on_i};
                    launch_s      = !drv.busy;
                    send_disp_s   = launch_s;
                    clr_ctrl_s[1] = launch_s;
                end else if (test_pend_s) begin
                    cmd_addr_d    = REG_TEST;
                    cmd_data_d    = {7'b0000000, test_mode_i};
                    launch_s      = !drv.busy;
                    send_test_s   = launch_s;
                    clr_ctrl_s[0] = launch_s;
                end else if (row_any_s) begin
                    // Captured from the registered framebuffer, so a write landing
                    // on the same edge is not included and re-marks the row dirty.
                    cmd_addr_d = {5'b00000, row_sel_s} + 8'd1;
                    cmd_data_d = fb_q[row_sel_s];
                    launch_s   = !drv.busy;
                    clr_row_s  = launch_s ? 8'(8'd1 << row_sel_s) : 8'h00;
                end else begin
                    launch_s   = 1'b0;
                end
            end
            default: begin
                launch_s = 1'b0;
            end
        endcase
    end

    // Dirty mask update: launch clears, refresh and user writes set; set wins.
    always_comb begin
        row_dirty_d  = row_dirty_q & ~clr_row_s;
        ctrl_dirty_d = ctrl_dirty_q & ~clr_ctrl_s;
        if (refresh_wrap_s) begin
            row_dirty_d  = 8'hFF;
            ctrl_dirty_d = 2'b11;
        end else begin
            row_dirty_d  = row_dirty_d;
            ctrl_dirty_d = ctrl_dirty_d;
        end
        if (row_we_i) begin
            row_dirty_d[row_addr_i] = 1'b1;
        end else begin
            row_dirty_d = row_dirty_d;
        end
    end

    // Framebuffer storage, written directly by user logic.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                fb_q[i] <= 8'h00;
            end
        end else if (row_we_i) begin
            fb_q[row_addr_i] <= row_data_i;
        end
    end

    // Dirty bookkeeping; every row starts dirty so the panel is cleared after init.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            row_dirty_q  <= 8'hFF;
            ctrl_dirty_q <= 2'b00;
        end else begin
            row_dirty_q  <= row_dirty_d;
            ctrl_dirty_q <= ctrl_dirty_d;
        end
    end

    // Free-running refresh divider; held at zero when refresh is disabled.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            refresh_cnt_q <= 32'd0;
        end else if (REFRESH_DIV == 0) begin
            refresh_cnt_q <= 32'd0;
        end else if (refresh_wrap_s) begin
            refresh_cnt_q <= 32'd0;
        end else begin
            refresh_cnt_q <= refresh_cnt_q + 32'd1;
        end
    end

    // Sequencer FSM with registered command outputs and handshake tracking.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            str_q       <= 1'b0;
            ir_q        <= 8'h00;
            data_q      <= 8'h00;
            ack_err_q   <= 1'b0;
            init_idx_q  <= 3'd0;
            init_done_q <= 1'b0;
            wait_cnt_q  <= 16'd0;
            sent_disp_q <= 1'b0;
            sent_test_q <= 1'b0;
        end else begin
            if (send_disp_s) begin
                sent_disp_q <= disp_on_i;
            end
            if (send_test_s) begin
                sent_test_q <= test_mode_i;
            end
            case (state_q)
                ST_INIT: begin
                    if (launch_s) begin
                        ir_q       <= cmd_addr_d;
                        data_q     <= cmd_data_d;
                        str_q      <= 1'b1;
                        init_idx_q <= init_idx_q + 3'd1;
                        if (init_idx_q == INIT_LAST) begin
                            init_done_q <= 1'b1;
                        end
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_SELECT: begin
                    if (launch_s) begin
                        ir_q    <= cmd_addr_d;
                        data_q  <= cmd_data_d;
                        str_q   <= 1'b1;
                        state_q <= ST_ISSUE;
                    end else if (!any_pending_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    str_q      <= 1'b0;
                    wait_cnt_q <= 16'd0;
                    state_q    <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (drv.busy) begin
                        state_q <= ST_WAIT_LO;
                    end else if (wait_cnt_q == ACK_LAST) begin
                        // Driver never acknowledged; flag it and move on rather than stall.
                        ack_err_q <= 1'b1;
                        state_q   <= ST_WAIT_LO;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!drv.busy) begin
                        state_q <= init_done_q ? ST_SELECT : ST_INIT;
                    end
                end
                ST_IDLE: begin
                    if (any_pending_s) begin
                        state_q <= ST_SELECT;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign drv.str   = str_q;
    assign drv.IRreg = ir_q;
    assign drv.data  = data_q;
    assign ack_err_o = ack_err_q;
    assign ready_o   = (state_q == ST_IDLE) && !any_pending_s && init_done_q;

endmodule
